xillybus_ev_out_source: RTL and testbench

//  Source end of the xillybus "ev_out" read stream (FPGA -> host). Accepts 16-bit event halfwords

---
 rtl/xillybus_ev_out_source.sv | 188 ++++++++++++++++++
 tb/tb_xillybus_ev_out_source.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xillybus_ev_out_source.sv
// xillybus_ev_out_source
//   Source end of the xillybus "ev_out" read stream (FPGA -> host). Event
//   halfwords from the readout path are packed in pairs into 32-bit words.
//   The first halfword of each pair goes in [15:0] and the second in [31:16].
//   Packed words are buffered in a FIFO that serves the core's user_r_ev_out_*
//   read port. The stream seen by the host always starts on an event boundary.
//   All logic runs on the rising edge of bus_clk_i.
//
// Ports
//   bus_clk_i              bus clock
//   rst_i                  synchronous, active-high reset
//   ev_dat_i/valid/last    event halfword stream input
//   ev_ready_o             halfword accepted when ev_valid_i && ev_ready_o
//   user_r_ev_out_rden_i   read enable from the core
//   user_r_ev_out_open_i   host has the device file open
//   user_r_ev_out_data_o   read data, valid the cycle after rden
//   user_r_ev_out_empty_o  FIFO holds no words
//   user_r_ev_out_eof_o    end-of-file (constant 0, the stream never ends)
//   fifo_count_o           words currently buffered
//   ev_count_o             events fully written to the FIFO (wraps)
//   ev_drop_count_o        events discarded (wraps)
module xillybus_ev_out_source #(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [15:0] PAD_HALF   = 16'h0000
) (
    input  logic                  bus_clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           ev_dat_i,
    input  logic                  ev_valid_i,
    input  logic                  ev_last_i,
    output logic                  ev_ready_o,
    input  logic                  user_r_ev_out_rden_i,
    input  logic                  user_r_ev_out_open_i,
    output logic [31:0]           user_r_ev_out_data_o,
    output logic                  user_r_ev_out_empty_o,
    output logic                  user_r_ev_out_eof_o,
    output logic [DEPTH_LOG2:0]   fifo_count_o,
    output logic [15:0]           ev_count_o,
    output logic [15:0]           ev_drop_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_DISCARD = 2'd0,
        ST_EVEN    = 2'd1,
        ST_ODD     = 2'd2
    } state_t;

    state_t state, state_next;

    logic                  in_event;
    logic [15:0]           low_half;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [31:0]           mem [DEPTH];

    logic                  hs;
    logic                  wr_en;
    logic [31:0]           wr_word;
    logic                  latch_low;
    logic                  ev_inc;
    logic                  drop_inc;
    logic                  wr_commit;
    logic                  rd_en;
    logic [DEPTH_LOG2:0]   count_next;

    // Ready depends only on registered state so there is no path from ev_valid_i.
    // In DISCARD everything is swallowed, so the source is never stalled there.
    assign ev_ready_o          = (state == ST_DISCARD) || (fifo_count_o != FULL_COUNT);
    assign hs                  = ev_valid_i && ev_ready_o;
    assign user_r_ev_out_eof_o = 1'b0;

    // A closed file flushes the FIFO, which takes priority over any write or read.
    assign wr_commit = wr_en && user_r_ev_out_open_i;
    assign rd_en     = user_r_ev_out_rden_i && !user_r_ev_out_empty_o && user_r_ev_out_open_i;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_word    = 32'h0;
        latch_low  = 1'b0;
        ev_inc     = 1'b0;
        drop_inc   = 1'b0;
        case (state)
            ST_DISCARD: begin
                if (hs && ev_last_i) begin
                    drop_inc = 1'b1;
                end
                // Leave only at an event boundary: idle outside an event, or
                // the last halfword of the event being dropped right now.
                if (user_r_ev_out_open_i &&
                    ((!in_event && !hs) || (hs && ev_last_i))) begin
                    state_next = ST_EVEN;
                end
            end
            ST_EVEN: begin
                if (hs) begin
                    if (ev_last_i) begin
                        wr_en   = 1'b1;
                        wr_word = {PAD_HALF, ev_dat_i};
                        ev_inc  = 1'b1;
                    end else begin
                        latch_low  = 1'b1;
                        state_next = ST_ODD;
                    end
                end
            end
            ST_ODD: begin
                if (hs) begin
                    wr_en      = 1'b1;
                    wr_word    = {ev_dat_i, low_half};
                    ev_inc     = ev_last_i;
                    state_next = ST_EVEN;
                end
            end
            default: state_next = ST_DISCARD;
        endcase
        if (!user_r_ev_out_open_i) begin
            state_next = ST_DISCARD;
        end
    end

    always_comb begin
        count_next = fifo_count_o;
        case ({wr_commit, rd_en})
            2'b10:   count_next = fifo_count_o + CNT_ONE;
            2'b01:   count_next = fifo_count_o - CNT_ONE;
            default: count_next = fifo_count_o;
        endcase
    end

    always_ff @(posedge bus_clk_i) begin
        if (rst_i) begin
            state                 <= ST_DISCARD;
            in_event              <= 1'b0;
            low_half              <= 16'h0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            fifo_count_o          <= '0;
            user_r_ev_out_empty_o <= 1'b1;
            user_r_ev_out_data_o  <= 32'h0;
            ev_count_o            <= 16'h0;
            ev_drop_count_o       <= 16'h0;
        end else begin
            state <= state_next;
            if (hs) begin
                in_event <= !ev_last_i;
            end
            if (latch_low) begin
                low_half <= ev_dat_i;
            end
            if (ev_inc) begin
                ev_count_o <= ev_count_o + 16'd1;
            end
            if (drop_inc) begin
                ev_drop_count_o <= ev_drop_count_o + 16'd1;
            end
            if (!user_r_ev_out_open_i) begin
                wr_ptr                <= '0;
                rd_ptr                <= '0;
                fifo_count_o          <= '0;
                user_r_ev_out_empty_o <= 1'b1;
            end else begin
                if (wr_commit) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_en) begin
                    user_r_ev_out_data_o <= mem[rd_ptr];
                    rd_ptr               <= rd_ptr + PTR_ONE;
                end
                fifo_count_o          <= count_next;
                user_r_ev_out_empty_o <= (count_next == '0);
            end
        end
    end

    // Storage array carries no reset; only the pointers define its contents.
    always_ff @(posedge bus_clk_i) begin
        if (wr_commit) begin
            mem[wr_ptr] <= wr_word;
        end
    end

endmodule

// File: tb/tb_xillybus_ev_out_source.sv
module tb_xillybus_ev_out_source;

    localparam int DL2 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   ev_dat;
    logic          ev_valid;
    logic          ev_last;
    logic          ev_ready;
    logic          rden;
    logic          open_f;
    logic [31:0]   data_o;
    logic          empty_o;
    logic          eof_o;
    logic [DL2:0]  fifo_count;
    logic [15:0]   ev_count;
    logic [15:0]   drop_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];

    typedef struct {
        logic        open;
        logic [15:0] dat;
        logic        last;
        logic        push;
        logic [31:0] word;
        logic [15:0] ev;
        logic [15:0] drop;
        logic        drn;
    } vec_t;

    vec_t tbl[15];

    xillybus_ev_out_source #(.DEPTH_LOG2(DL2), .PAD_HALF(16'h0000)) dut (
        .bus_clk_i             (clk),
        .rst_i                 (rst),
        .ev_dat_i              (ev_dat),
        .ev_valid_i            (ev_valid),
        .ev_last_i             (ev_last),
        .ev_ready_o            (ev_ready),
        .user_r_ev_out_rden_i  (rden),
        .user_r_ev_out_open_i  (open_f),
        .user_r_ev_out_data_o  (data_o),
        .user_r_ev_out_empty_o (empty_o),
        .user_r_ev_out_eof_o   (eof_o),
        .fifo_count_o          (fifo_count),
        .ev_count_o            (ev_count),
        .ev_drop_count_o       (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic o, input logic [15:0] d, input logic l,
                           input logic p, input logic [31:0] w, input logic [15:0] e,
                           input logic [15:0] dr, input logic dn);
        tbl[i].open = o;  tbl[i].dat = d;  tbl[i].last = l;  tbl[i].push = p;
        tbl[i].word = w;  tbl[i].ev = e;   tbl[i].drop = dr; tbl[i].drn = dn;
    endtask

    task automatic send_half(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        ev_dat   = d;
        ev_last  = l;
        ev_valid = 1'b1;
        while (!ev_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
        end
        step();
        ev_valid = 1'b0;
        ev_last  = 1'b0;
    endtask

    task automatic rd_word();
        rden = 1'b1;
        step();
        rden = 1'b0;
    endtask

    task automatic drain();
        logic [31:0] exp;
        while (q.size() > 0) begin
            exp = q.pop_front();
            rd_word();
            chk("rd_data", data_o, exp);
        end
        chk("drain_empty", 32'(empty_o), 32'd1);
        chk("drain_count", 32'(fifo_count), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data"},  data_o, 32'h0);
        chk({tag, "_empty"}, 32'(empty_o), 32'd1);
        chk({tag, "_eof"},   32'(eof_o), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_ev"},    32'(ev_count), 32'd0);
        chk({tag, "_drop"},  32'(drop_count), 32'd0);
        chk({tag, "_ready"}, 32'(ev_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] exp;

        // Test 1 (rows 0-3), test 2 (rows 4-6), test 3 (rows 7-14).
        set_vec(0,  1, 16'h0001, 0, 0, 32'h0,          16'd0, 16'd0, 0);
        set_vec(1,  1, 16'h0002, 0, 1, 32'h0002_0001,  16'd0, 16'd0, 0);
        set_vec(2,  1, 16'h0003, 0, 0, 32'h0,          16'd0, 16'd0, 0);
        set_vec(3,  1, 16'h0004, 1, 1, 32'h0004_0003,  16'd1, 16'd0, 0);
        set_vec(4,  1, 16'h000A, 0, 0, 32'h0,          16'd1, 16'd0, 0);
        set_vec(5,  1, 16'h000B, 0, 1, 32'h000B_000A,  16'd1, 16'd0, 0);
        set_vec(6,  1, 16'h000C, 1, 1, 32'h0000_000C,  16'd2, 16'd0, 1);
        set_vec(7,  0, 16'h0010, 0, 0, 32'h0,          16'd2, 16'd0, 0);
        set_vec(8,  0, 16'h0011, 0, 0, 32'h0,          16'd2, 16'd0, 0);
        set_vec(9,  1, 16'h0012, 0, 0, 32'h0,          16'd2, 16'd0, 0);
        set_vec(10, 1, 16'h0013, 0, 0, 32'h0,          16'd2, 16'd0, 0);
        set_vec(11, 1, 16'h0014, 0, 0, 32'h0,          16'd2, 16'd0, 0);
        set_vec(12, 1, 16'h0015, 1, 0, 32'h0,          16'd2, 16'd1, 0);
        set_vec(13, 1, 16'h0020, 0, 0, 32'h0,          16'd2, 16'd1, 0);
        set_vec(14, 1, 16'h0021, 1, 1, 32'h0021_0020,  16'd3, 16'd1, 1);

        rst = 1'b1; ev_dat = 16'h0; ev_valid = 1'b0; ev_last = 1'b0;
        rden = 1'b0; open_f = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_reset_values("reset");

        open_f = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            open_f = tbl[i].open;
            if (tbl[i].push) q.push_back(tbl[i].word);
            send_half(tbl[i].dat, tbl[i].last);
            chk($sformatf("row%0d_ev", i),    32'(ev_count), 32'(tbl[i].ev));
            chk($sformatf("row%0d_drop", i),  32'(drop_count), 32'(tbl[i].drop));
            chk($sformatf("row%0d_count", i), 32'(fifo_count), 32'(q.size()));
            if (tbl[i].drn) drain();
        end

        // Read while empty is ignored and data_o holds.
        prev = data_o;
        rd_word();
        chk("empty_read_hold", data_o, prev);
        chk("empty_read_count", 32'(fifo_count), 32'd0);

        // Test 4: fill to 16 words.
        for (int k = 0; k < 16; k++) begin
            q.push_back({16'h0100 + 16'(2 * k + 1), 16'h0100 + 16'(2 * k)});
            send_half(16'h0100 + 16'(2 * k), 1'b0);
            send_half(16'h0100 + 16'(2 * k + 1), 1'b1);
        end
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_ready", 32'(ev_ready), 32'd0);
        chk("full_ev", 32'(ev_count), 32'd19);
        exp = q.pop_front();
        rd_word();
        chk("full_rd_data", data_o, exp);
        chk("full_ready_back", 32'(ev_ready), 32'd1);
        chk("full_count_after", 32'(fifo_count), 32'd15);
        drain();

        // Test 5: reader every cycle, writer one word every other cycle.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send_half(16'h0200 + 16'(2 * k), 1'b0);
                    q.push_back({16'h0200 + 16'(2 * k + 1), 16'h0200 + 16'(2 * k)});
                    send_half(16'h0200 + 16'(2 * k + 1), 1'b1);
                end
            end
            begin
                int got;
                logic eff;
                logic [31:0] held;
                logic [31:0] want;
                got = 0;
                held = data_o;
                for (int c = 0; c < 60 && got < 8; c++) begin
                    eff = !empty_o;
                    rden = 1'b1;
                    step();
                    if (eff) begin
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL stream_underflow: got a read with no expected word");
                        end else begin
                            want = q.pop_front();
                            chk("stream_data", data_o, want);
                        end
                        held = data_o;
                        got++;
                    end else begin
                        chk("stream_hold", data_o, held);
                    end
                end
                rden = 1'b0;
                chk("stream_reads", 32'(got), 32'd8);
            end
        join
        chk("stream_qempty", 32'(q.size()), 32'd0);
        chk("stream_ev", 32'(ev_count), 32'd27);

        // Test 6: close with 5 words buffered and a low half held.
        for (int k = 0; k < 5; k++) begin
            send_half(16'h0300 + 16'(2 * k), 1'b0);
            send_half(16'h0300 + 16'(2 * k + 1), 1'b1);
        end
        send_half(16'h03F0, 1'b0);
        chk("close_pre_count", 32'(fifo_count), 32'd5);
        open_f = 1'b0;
        step();
        q.delete();
        chk("close_count", 32'(fifo_count), 32'd0);
        chk("close_empty", 32'(empty_o), 32'd1);
        send_half(16'h03F1, 1'b1);
        chk("close_drop", 32'(drop_count), 32'd2);
        chk("close_ev", 32'(ev_count), 32'd32);

        // Reset in the middle of an event with a word buffered.
        open_f = 1'b1;
        step();
        send_half(16'h0400, 1'b0);
        send_half(16'h0401, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
